// File: rtl/clock_display_mux.sv
// Time-multiplexed driver for a four-digit HH:MM seven-segment display.
// The colon is driven on dp, and the whole display blinks while the alarm is active.
module clock_display_mux #(
    parameter int SCAN_DIV     = 2500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic       alarm,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [7:0]    FRAME_MAX = 8'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        DIGIT_HOUR_TENS,
        DIGIT_HOUR_ONES,
        DIGIT_MIN_TENS,
        DIGIT_MIN_ONES
    } digit_t;

    logic [PW-1:0] prescaler;
    digit_t        index;
    logic [7:0]    frame_cnt;
    logic          phase;
    logic [4:0]    snap_hours;
    logic [5:0]    snap_minutes;
    logic          snap_alarm;

    logic          scan_tick;
    logic          frame_tick;
    logic          blank;
    logic [3:0]    h_tens, h_ones, m_tens, m_ones;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = SEG_DASH;
        endcase
    endfunction

    assign scan_tick  = (prescaler == PRESC_MAX);
    assign frame_tick = scan_tick && (index == DIGIT_MIN_ONES);
    assign blank      = snap_alarm && phase;

    // Binary-to-BCD by repeated comparison; the last matching decade wins.
    always_comb begin
        h_tens = 4'd0;
        h_ones = 4'(snap_hours);
        m_tens = 4'd0;
        m_ones = 4'(snap_minutes);
        for (int k = 1; k <= 2; k++) begin
            if (snap_hours >= 5'(10 * k)) begin
                h_tens = 4'(k);
                h_ones = 4'(snap_hours - 5'(10 * k));
            end
        end
        for (int k = 1; k <= 5; k++) begin
            if (snap_minutes >= 6'(10 * k)) begin
                m_tens = 4'(k);
                m_ones = 4'(snap_minutes - 6'(10 * k));
            end
        end
    end

    always_comb begin
        seg_next = 7'h00;
        case (index)
            DIGIT_HOUR_TENS: seg_next = (snap_hours > 5'd23)   ? SEG_DASH : seg_of(h_tens);
            DIGIT_HOUR_ONES: seg_next = (snap_hours > 5'd23)   ? SEG_DASH : seg_of(h_ones);
            DIGIT_MIN_TENS:  seg_next = (snap_minutes > 6'd59) ? SEG_DASH : seg_of(m_tens);
            DIGIT_MIN_ONES:  seg_next = (snap_minutes > 6'd59) ? SEG_DASH : seg_of(m_ones);
            default:         seg_next = 7'h00;
        endcase
    end

    // Outputs are computed from this cycle's state, so they lag it by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler    <= '0;
            index        <= DIGIT_HOUR_TENS;
            frame_cnt    <= 8'd0;
            phase        <= 1'b0;
            snap_hours   <= 5'd0;
            snap_minutes <= 6'd0;
            snap_alarm   <= 1'b0;
            seg          <= 7'h00;
            dp           <= 1'b0;
            digit_en     <= 4'b0000;
        end else begin
            prescaler <= scan_tick ? '0 : prescaler + PW'(1);
            if (scan_tick)
                index <= digit_t'(index + 2'd1);
            if (frame_tick) begin
                if (frame_cnt == FRAME_MAX) begin
                    frame_cnt <= 8'd0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            if (index == DIGIT_HOUR_TENS && prescaler == '0) begin
                snap_hours   <= hours;
                snap_minutes <= minutes;
                snap_alarm   <= alarm;
            end
            seg      <= blank ? 7'h00 : seg_next;
            digit_en <= blank ? 4'b0000 : (4'b0001 << index);
            dp       <= !blank && (index == DIGIT_HOUR_ONES) && !phase;
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// Randomized self-checking bench for clock_display_mux against a timeline-based
// reference model: display state is derived from the number of edges since reset.
module tb_clock_display_mux;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       alarm;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit_en;

    int checks = 0;
    int failures = 0;

    // Model state: edges since reset release and the frame's captured inputs.
    int t = 0;
    int snap_h = 0;
    int snap_m = 0;
    bit snap_a = 1'b0;

    logic [6:0] seg_table [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    clock_display_mux #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hours    (hours),
        .minutes  (minutes),
        .alarm    (alarm),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] expectedDisplay(int tt, int sh, int sm, bit sa);
        int idx = (tt / SD) % 4;
        int ph = (tt / (FRAME * BF)) % 2;
        int digit = 0;
        bit dash;
        logic [6:0] s;
        if (sa && ph == 1)
            return 12'h000;
        case (idx)
            0: begin dash = sh > 23; digit = sh / 10; end
            1: begin dash = sh > 23; digit = sh % 10; end
            2: begin dash = sm > 59; digit = sm / 10; end
            default: begin dash = sm > 59; digit = sm % 10; end
        endcase
        s = dash ? 7'h40 : seg_table[digit];
        return {s, (idx == 1 && ph == 0), 4'(1 << idx)};
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s t=%0d: got seg=%h dp=%b en=%b, expected seg=%h dp=%b en=%b",
                     tag, t, observed[11:5], observed[4], observed[3:0],
                     expected[11:5], expected[4], expected[3:0]);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check just after the rising edge.
    task automatic applyStimulus(input string tag, input bit r, input int h, input int m, input bit a);
        logic [11:0] exp_val;
        @(negedge clk);
        rst_n   = r;
        hours   = 5'(h);
        minutes = 6'(m);
        alarm   = a;
        @(posedge clk);
        if (!r) begin
            exp_val = 12'h000;
            t = 0;
            snap_h = 0;
            snap_m = 0;
            snap_a = 1'b0;
        end else begin
            exp_val = expectedDisplay(t, snap_h, snap_m, snap_a);
            if (t % FRAME == 0) begin
                snap_h = h;
                snap_m = m;
                snap_a = a;
            end
            t++;
        end
        #1;
        checkOutput(tag, {seg, dp, digit_en}, exp_val);
    endtask

    initial begin
        int h, m;
        bit a;
        rst_n = 1'b0;
        hours = '0;
        minutes = '0;
        alarm = 1'b0;

        repeat (3) applyStimulus("reset", 1'b0, 13, 47, 1'b0);
        repeat (8) applyStimulus("hm_13_47", 1'b1, 13, 47, 1'b0);
        repeat (72) applyStimulus("min_change", 1'b1, 13, 48, 1'b0);
        repeat (32) applyStimulus("lead_zero", 1'b1, 9, 5, 1'b0);
        repeat (32) applyStimulus("hours_oor", 1'b1, 25, 59, 1'b0);
        repeat (32) applyStimulus("min_oor", 1'b1, 13, 60, 1'b0);
        repeat (32) applyStimulus("max_time", 1'b1, 23, 59, 1'b0);
        repeat (130) applyStimulus("alarm_on", 1'b1, 12, 34, 1'b1);
        repeat (70) applyStimulus("alarm_off", 1'b1, 12, 34, 1'b0);
        repeat (100) applyStimulus("alarm_blink", 1'b1, 7, 30, 1'b1);
        applyStimulus("reset_pulse", 1'b0, 7, 30, 1'b1);
        repeat (80) applyStimulus("after_reset", 1'b1, 7, 30, 1'b1);

        h = 13; m = 47; a = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) h = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) m = $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) a = 1'($urandom_range(0, 1));
            applyStimulus("random", ($urandom_range(0, 299) != 0), h, m, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_display_mux.md
CLOCK_DISPLAY_MUX -- requirements
Module: clock_display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 2500, clock cycles each digit stays selected; legal range 2..65535.
REQ-002 Parameter BLINK_FRAMES, default 125, full 4-digit frames per blink-phase toggle; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 hours  input  5  current hour, binary, legal 0..23.
REQ-006 minutes  input  6  current minute, binary, legal 0..59.
REQ-007 alarm  input  1  alarm-active flag from the alarm clock core.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
REQ-009 dp  output  1  decimal point, used as colon, active-high.
REQ-010 digit_en  output  4  one-hot digit select, active-high; bit0 = hours tens, bit1 = hours ones, bit2 = minutes tens, bit3 = minutes ones.

Function
REQ-011 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; a scan tick is the cycle where the prescaler equals SCAN_DIV-1.
REQ-012 Digit index (0..3) increments on each scan tick and wraps 3->0; a frame tick is a scan tick with index 3.
REQ-013 Snapshot registers capture hours, minutes and alarm on every cycle where index==0 and prescaler==0; they hold at all other times, so no frame mixes two input samples.
REQ-014 Frame counter counts 0..BLINK_FRAMES-1 on frame ticks; on the frame tick where it wraps to 0, the blink phase toggles.
REQ-015 Decode: snapshot hours 0..23 -> tens/ones; snapshot minutes 0..59 -> tens/ones; tens digits always shown, including a leading zero.
REQ-016 Out-of-range snapshot (hours>23 or minutes>59): both digits of that field show a dash (7'h40); the other field decodes normally.
REQ-017 Digit encodings: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex, seg[6:0]).
REQ-018 Outputs are registered: seg, dp and digit_en at cycle N reflect index, phase and snapshot register values of cycle N-1.
REQ-019 Normal (snapshot alarm=0): digit_en = 1<<index; seg = encoding of the selected digit.
REQ-020 dp = 1 only when index==1 and phase==0, and only when not blanked; otherwise dp = 0.
REQ-021 Alarm blink (snapshot alarm=1): when phase==1, digit_en, seg and dp are 0; when phase==0, the display is normal.
REQ-022 Deasserting alarm takes effect at the next snapshot capture, with no partial-frame blanking; the phase counter runs regardless of alarm.
REQ-023 Inputs are not checked for X; only the range rules of REQ-016 apply.

Reset
REQ-024 With rst_n=0 at a rising edge: prescaler, index, frame counter, phase and snapshots are cleared to 0; seg=0, dp=0, digit_en=0.
REQ-025 Reset asserted mid-frame or mid-blink aborts immediately; the first edge after release behaves as REQ-013 (capture) with index 0.
REQ-026 The first edge after release drives digit_en=4'b0001 and seg=7'h3F (from cleared snapshot); from the second edge, the new snapshot is displayed.

Verification (SCAN_DIV=4, BLINK_FRAMES=2 unless stated)
REQ-027 hours=13, minutes=47, alarm=0, release reset -> per 4-cycle slot: digit_en 0001/0010/0100/1000 with seg 06/4F/66/07; dp=1 only in slot 0010 during phase 0.
REQ-028 hours=9, minutes=5 -> seg sequence 3F,6F,3F,6D (leading zeros shown).
REQ-029 Change minutes 47->48 while index==2 -> current frame still shows 4,7; next frame shows 4,8.
REQ-030 hours=25, minutes=59 -> hour digits seg=40, 40; minute digits 6D, 6F.
REQ-031 alarm=1 held -> 2 frames (32 cycles) displayed, then 2 frames with digit_en=0, seg=0, dp=0, repeating; deasserting alarm restores a full display from the next frame start.
REQ-032 Pulse rst_n=0 for one cycle mid-blink -> outputs are 0 on the next edge, then the REQ-026 sequence follows with phase=0.
